// File: rtl/recur_pkg.sv
// Shared constants, state-word field map and FSM encoding for the
// inexact-recursion call-stack controller.
package recur_pkg;
    localparam int STATE_W    = 18;
    localparam int IZKL_W     = 32;
    localparam int POS_MSB    = 17;
    localparam int POS_LSB    = 13;
    localparam int PARENT_MSB = 12;
    localparam int PARENT_LSB = 1;
    localparam int FIN_BIT    = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_ISSUE,
        S_WAIT,
        S_POP
    } rs_state_e;

    // Field update: bit 0 set means "mark finished", otherwise replace position.
    function automatic logic [STATE_W-1:0] merge_field(input logic [STATE_W-1:0] base,
                                                       input logic [STATE_W-1:0] upd);
        merge_field = base;
        if (upd[FIN_BIT]) merge_field[FIN_BIT] = 1'b1;
        else              merge_field[POS_MSB:POS_LSB] = upd[POS_MSB:POS_LSB];
    endfunction
endpackage

// File: rtl/recur_mem.sv
// Simple dual-port array with registered read. Port A (push) owns the write
// port; a colliding port-B write is parked for one cycle and bypassed on read.
module recur_mem #(
    parameter int AW = 12,
    parameter int W  = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_a_i,
    input  logic [AW-1:0] waddr_a_i,
    input  logic [W-1:0]  wdata_a_i,
    input  logic          we_b_i,
    input  logic [AW-1:0] waddr_b_i,
    input  logic [W-1:0]  wdata_b_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0]  mem_q [1<<AW];
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [W-1:0]  pend_data_q, pend_data_d;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  rd_q;

    always_comb begin
        wr_en       = 1'b0;
        wr_addr     = waddr_a_i;
        wr_data     = wdata_a_i;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        if (we_a_i) begin
            wr_en = 1'b1;
            if (we_b_i) begin
                pend_d      = 1'b1;
                pend_addr_d = waddr_b_i;
                pend_data_d = wdata_b_i;
            end
        end else if (pend_q) begin
            wr_en       = 1'b1;
            wr_addr     = pend_addr_q;
            wr_data     = pend_data_q;
            pend_d      = we_b_i;
            pend_addr_d = waddr_b_i;
            pend_data_d = wdata_b_i;
        end else if (we_b_i) begin
            wr_en   = 1'b1;
            wr_addr = waddr_b_i;
            wr_data = wdata_b_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            rd_q        <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            if (re_i) rd_q <= (pend_q && pend_addr_q == raddr_i) ? pend_data_q : mem_q[raddr_i];
        end
    end

    assign rdata_o = rd_q;
endmodule

// File: rtl/recur_stack_ctrl.sv
// Call-stack store and scheduler: absorbs write-back pushes/field updates,
// presents top-of-stack to fetch, pops finished calls, flags empty/overflow.
module recur_stack_ctrl
    import recur_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IZKL_W-1:0]  root_izkl,
    input  logic               seq_we_state,
    input  logic [STATE_W-1:0] seq_w_data_state,
    input  logic               seq_we_InexRecur,
    input  logic [IZKL_W-1:0]  seq_w_data_InexRecur,
    input  logic               ran_we_state,
    input  logic [STATE_W-1:0] ran_w_data_state,
    input  logic [AW-1:0]      ran_w_addr_state,
    input  logic               ran_we_InexRecur,
    input  logic [IZKL_W-1:0]  ran_w_data_InexRecur,
    input  logic [AW-1:0]      ran_w_addr_InexRecur,
    input  logic               wb_commit,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [AW-1:0]      fetch_addr,
    output logic [STATE_W-1:0] fetch_state,
    output logic [IZKL_W-1:0]  fetch_izkl,
    output logic               busy,
    output logic               done,
    output logic               overflow
);
    localparam logic [AW:0] TAIL_ONE = (AW+1)'(1);

    rs_state_e          state_q, state_d;
    logic [AW:0]        tail_q, tail_d;
    logic               overflow_q, overflow_d;
    logic [AW-1:0]      fetch_addr_q, fetch_addr_d;
    logic [STATE_W-1:0] shadow_q, shadow_d;
    logic               ld_q;

    logic [AW-1:0]      top_addr, push_addr;
    logic               do_start, push, full, push_ok, drop, fin_set;
    logic [STATE_W-1:0] rd_state, merged;
    logic [IZKL_W-1:0]  rd_izkl;

    assign top_addr  = tail_q[AW-1:0] - AW'(1);
    assign do_start  = (state_q == S_IDLE) && start;
    assign push      = wb_commit && (seq_we_state || seq_we_InexRecur) && !do_start;
    assign full      = tail_q[AW] && (state_q != S_POP);
    assign push_ok   = push && !full;
    assign drop      = push && full;
    // A push landing in the pop cycle takes the slot being vacated.
    assign push_addr = (state_q == S_POP) ? top_addr : tail_q[AW-1:0];
    assign fin_set   = wb_commit && ran_we_state && ran_w_data_state[FIN_BIT]
                       && (ran_w_addr_state == top_addr);
    // Shadow tracks the top word; the fresh read is used in the first ISSUE cycle.
    assign merged    = merge_field(ld_q ? rd_state : shadow_q, ran_w_data_state);

    recur_mem #(.AW(AW), .W(STATE_W)) u_state_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_a_i    (do_start || (push_ok && seq_we_state)),
        .waddr_a_i (do_start ? '0 : push_addr),
        .wdata_a_i (do_start ? '0 : seq_w_data_state),
        .we_b_i    (wb_commit && ran_we_state),
        .waddr_b_i (ran_w_addr_state),
        .wdata_b_i (merged),
        .re_i      (state_q == S_RD),
        .raddr_i   (top_addr),
        .rdata_o   (rd_state)
    );

    recur_mem #(.AW(AW), .W(IZKL_W)) u_izkl_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_a_i    (do_start || (push_ok && seq_we_InexRecur)),
        .waddr_a_i (do_start ? '0 : push_addr),
        .wdata_a_i (do_start ? root_izkl : seq_w_data_InexRecur),
        .we_b_i    (wb_commit && ran_we_InexRecur),
        .waddr_b_i (ran_w_addr_InexRecur),
        .wdata_b_i (ran_w_data_InexRecur),
        .re_i      (state_q == S_RD),
        .raddr_i   (top_addr),
        .rdata_o   (rd_izkl)
    );

    always_comb begin
        state_d      = state_q;
        tail_d       = tail_q;
        overflow_d   = overflow_q;
        fetch_addr_d = fetch_addr_q;
        shadow_d     = shadow_q;
        done         = 1'b0;
        if (ld_q) shadow_d = rd_state;
        if (wb_commit && ran_we_state) shadow_d = merged;
        if (push_ok) tail_d = tail_q + TAIL_ONE;
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d    = S_RD;
                tail_d     = TAIL_ONE;
                overflow_d = 1'b0;
            end
            S_RD: begin
                fetch_addr_d = top_addr;
                state_d      = S_ISSUE;
            end
            S_ISSUE: if (fetch_ready) state_d = S_WAIT;
            S_WAIT: if (wb_commit) begin
                if (push_ok)      state_d = S_RD;
                else if (fin_set) state_d = S_POP;
                else              state_d = S_RD;
            end
            S_POP: begin
                tail_d = push_ok ? tail_q : tail_q - TAIL_ONE;
                if (tail_d == '0) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            state_d    = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tail_q       <= '0;
            overflow_q   <= 1'b0;
            fetch_addr_q <= '0;
            shadow_q     <= '0;
            ld_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            tail_q       <= tail_d;
            overflow_q   <= overflow_d;
            fetch_addr_q <= fetch_addr_d;
            shadow_q     <= shadow_d;
            ld_q         <= (state_q == S_RD);
        end
    end

    assign fetch_valid = (state_q == S_ISSUE);
    assign busy        = (state_q != S_IDLE);
    assign fetch_addr  = fetch_addr_q;
    assign fetch_state = rd_state;
    assign fetch_izkl  = rd_izkl;
    assign overflow    = overflow_q;
endmodule
